// File: rtl/vc_pkg.sv
// Shared definitions for the vehicle counter: day codes, week-state encoding
// and the width rule for the summed counters.
package vc_pkg;

  localparam logic [2:0] DAY_MON = 3'd1;
  localparam logic [2:0] DAY_TUE = 3'd2;
  localparam logic [2:0] DAY_WED = 3'd3;
  localparam logic [2:0] DAY_THU = 3'd4;
  localparam logic [2:0] DAY_FRI = 3'd5;
  localparam logic [2:0] DAY_SAT = 3'd6;
  localparam logic [2:0] DAY_SUN = 3'd7;

  typedef enum logic [0:0] {
    IN_WEEK  = 1'b0,
    LAST_DAY = 1'b1
  } week_state_e;

  // Wide enough for N_LANES saturated lane counters with one bit of headroom.
  function automatic int total_w(input int n_lanes, input int cnt_w);
    return cnt_w + $clog2(n_lanes) + 1;
  endfunction

endpackage

// File: rtl/vehicle_counter_multi_if.sv
// Bus between the plate-reader front end and the vehicle counter.
interface vehicle_counter_multi_if
  import vc_pkg::*;
#(
  parameter int N_LANES = 2,
  parameter int PLATE_W = 24,
  parameter int CNT_W   = 4
) ();

  localparam int TOT_W = total_w(N_LANES, CNT_W);

  logic [2:0]                 day;
  logic [N_LANES-1:0]         plate_valid;
  logic [N_LANES*PLATE_W-1:0] plate;
  logic [N_LANES-1:0]         barrier_n;
  logic [N_LANES*CNT_W-1:0]   lane_count;
  logic [TOT_W-1:0]           total_count;
  logic [N_LANES-1:0]         lane_sat;
  logic                       week_done;
  logic [TOT_W-1:0]           last_week_total;

  modport master (
    output day, plate_valid, plate, barrier_n,
    input  lane_count, total_count, lane_sat, week_done, last_week_total
  );

  modport slave (
    input  day, plate_valid, plate, barrier_n,
    output lane_count, total_count, lane_sat, week_done, last_week_total
  );

endinterface

// File: rtl/vc_lane.sv
// One barrier lane: recent-plate history with valid bits, duplicate match,
// saturating weekly counter and sticky saturation flag.
module vc_lane
  import vc_pkg::*;
#(
  parameter int PLATE_W    = 24,
  parameter int CNT_W      = 4,
  parameter int HIST_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               plate_valid,
  input  logic [PLATE_W-1:0] plate,
  input  logic               barrier_n,
  output logic [CNT_W-1:0]   count,
  output logic               sat,
  output logic               inc
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PLATE_W-1:0]    hist_r [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] hist_vld_r;
  logic [CNT_W-1:0]      count_r;
  logic                  sat_r;
  logic                  match_s;
  logic                  accept_s;
  logic                  at_max_s;

  // Compare the incoming plate against every valid history entry.
  always_comb begin
    match_s = 1'b0;
    for (int k = 0; k < HIST_DEPTH; k++) begin
      if (hist_vld_r[k] && (hist_r[k] == plate)) begin
        match_s = 1'b1;
      end else begin
        match_s = match_s;
      end
    end
  end

  assign accept_s = plate_valid & ~barrier_n & ~match_s;
  assign at_max_s = (count_r == CNT_MAX);
  // During rollover the counter restarts from zero, so saturation no longer blocks.
  assign inc      = accept_s & (clr | ~at_max_s);

  // History shift register: newest at index 0, oldest falls off the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_vld_r <= '0;
      for (int k = 0; k < HIST_DEPTH; k++) begin
        hist_r[k] <= '0;
      end
    end else if (accept_s) begin
      hist_r[0]     <= plate;
      hist_vld_r[0] <= 1'b1;
      for (int k = 1; k < HIST_DEPTH; k++) begin
        hist_r[k]     <= hist_r[k-1];
        hist_vld_r[k] <= hist_vld_r[k-1];
      end
    end else begin
      hist_vld_r <= hist_vld_r;
    end
  end

  // Saturating weekly counter and sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
      sat_r   <= 1'b0;
    end else if (clr) begin
      count_r <= accept_s ? CNT_W'(1) : '0;
      sat_r   <= 1'b0;
    end else begin
      if (inc) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
      if (accept_s && at_max_s) begin
        sat_r <= 1'b1;
      end else begin
        sat_r <= sat_r;
      end
    end
  end

  assign count = count_r;
  assign sat   = sat_r;

endmodule

// File: rtl/vehicle_counter_multi.sv
// Multi-lane vehicle counter: per-lane duplicate-suppressing counters, running
// weekly total, week rollover state machine and last-week snapshot.
module vehicle_counter_multi
  import vc_pkg::*;
#(
  parameter int         N_LANES      = 2,
  parameter int         PLATE_W      = 24,
  parameter int         CNT_W        = 4,
  parameter int         HIST_DEPTH   = 4,
  parameter logic [2:0] WEEK_END_DAY = DAY_SUN
) (
  input logic                    clk,
  input logic                    rst_n,
  vehicle_counter_multi_if.slave bus
);

  localparam int TOT_W = total_w(N_LANES, CNT_W);

  week_state_e              state_r;
  week_state_e              state_nxt_s;
  logic                     rollover_s;
  logic [N_LANES-1:0]       inc_s;
  logic [N_LANES-1:0]       sat_s;
  logic [N_LANES*CNT_W-1:0] count_s;
  logic [TOT_W-1:0]         inc_sum_s;
  logic [TOT_W-1:0]         total_r;
  logic [TOT_W-1:0]         last_total_r;
  logic                     week_done_r;

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    vc_lane #(
      .PLATE_W    (PLATE_W),
      .CNT_W      (CNT_W),
      .HIST_DEPTH (HIST_DEPTH)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (rollover_s),
      .plate_valid (bus.plate_valid[i]),
      .plate       (bus.plate[i*PLATE_W +: PLATE_W]),
      .barrier_n   (bus.barrier_n[i]),
      .count       (count_s[i*CNT_W +: CNT_W]),
      .sat         (sat_s[i]),
      .inc         (inc_s[i])
    );
  end

  // Number of lanes whose counter actually advances this cycle.
  always_comb begin
    inc_sum_s = '0;
    for (int i = 0; i < N_LANES; i++) begin
      inc_sum_s = inc_sum_s + TOT_W'(inc_s[i]);
    end
  end

  // Week state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IN_WEEK;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Week next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IN_WEEK:  state_nxt_s = (bus.day == WEEK_END_DAY) ? LAST_DAY : IN_WEEK;
      LAST_DAY: state_nxt_s = (bus.day == WEEK_END_DAY) ? LAST_DAY : IN_WEEK;
      default:  state_nxt_s = IN_WEEK;
    endcase
  end

  // Rollover fires on the cycle the day leaves the week-end day.
  always_comb begin
    rollover_s = 1'b0;
    case (state_r)
      LAST_DAY: rollover_s = (bus.day != WEEK_END_DAY);
      IN_WEEK:  rollover_s = 1'b0;
      default:  rollover_s = 1'b0;
    endcase
  end

  // Running total, rollover pulse and last-week snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_r      <= '0;
      last_total_r <= '0;
      week_done_r  <= 1'b0;
    end else if (rollover_s) begin
      total_r      <= inc_sum_s;
      last_total_r <= total_r;
      week_done_r  <= 1'b1;
    end else begin
      total_r      <= total_r + inc_sum_s;
      last_total_r <= last_total_r;
      week_done_r  <= 1'b0;
    end
  end

  assign bus.lane_count      = count_s;
  assign bus.lane_sat        = sat_s;
  assign bus.total_count     = total_r;
  assign bus.week_done       = week_done_r;
  assign bus.last_week_total = last_total_r;

endmodule

// File: tb/tb_vehicle_counter_multi.sv
// Bench for vehicle_counter_multi: two instances (history depth 4 and 1) driven
// in lockstep, compared every cycle against a queue-based reference model.
module tb_vehicle_counter_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  day_d = 3'd1;
  logic [1:0]  valid_d = 2'b00;
  logic [1:0]  barrier_d = 2'b00;
  logic [23:0] plate0_d = 24'd0;
  logic [23:0] plate1_d = 24'd0;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state, indexed [instance][lane]
  logic [23:0] hist [2][2][$];
  int          cnt  [2][2];
  bit          sat  [2][2];
  int          lwt  [2];
  bit          wd_e;
  bit          last_day;

  always #5 clk = ~clk;

  vehicle_counter_multi_if #(.N_LANES(2), .PLATE_W(24), .CNT_W(4)) bus0 ();
  vehicle_counter_multi_if #(.N_LANES(2), .PLATE_W(24), .CNT_W(4)) bus1 ();

  assign bus0.day = day_d;  assign bus0.plate_valid = valid_d;
  assign bus0.barrier_n = barrier_d;  assign bus0.plate = {plate1_d, plate0_d};
  assign bus1.day = day_d;  assign bus1.plate_valid = valid_d;
  assign bus1.barrier_n = barrier_d;  assign bus1.plate = {plate1_d, plate0_d};

  vehicle_counter_multi #(.N_LANES(2), .PLATE_W(24), .CNT_W(4), .HIST_DEPTH(4),
                          .WEEK_END_DAY(3'd7)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  vehicle_counter_multi #(.N_LANES(2), .PLATE_W(24), .CNT_W(4), .HIST_DEPTH(1),
                          .WEEK_END_DAY(3'd7)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int hd(input int m);
    return (m == 0) ? 4 : 1;
  endfunction

  function automatic bit seen(input int m, input int l, input logic [23:0] p);
    foreach (hist[m][l][k]) if (hist[m][l][k] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sum_of(input int m);
    return cnt[m][0] + cnt[m][1];
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      lwt[m] = 0;
      for (int l = 0; l < 2; l++) begin
        hist[m][l].delete();
        cnt[m][l] = 0;
        sat[m][l] = 1'b0;
      end
    end
    wd_e = 1'b0;
    last_day = 1'b0;
  endtask

  // one clock edge worth of behaviour, using the inputs currently applied
  task automatic model_step();
    logic [23:0] pl [2];
    bit roll;
    pl[0] = plate0_d;
    pl[1] = plate1_d;
    roll = last_day && (day_d != 3'd7);
    wd_e = roll;
    last_day = (day_d == 3'd7);
    for (int m = 0; m < 2; m++) begin
      if (roll) begin
        lwt[m] = sum_of(m);
        for (int l = 0; l < 2; l++) begin
          cnt[m][l] = 0;
          sat[m][l] = 1'b0;
        end
      end
      for (int l = 0; l < 2; l++) begin
        if (valid_d[l] && !barrier_d[l] && !seen(m, l, pl[l])) begin
          hist[m][l].push_front(pl[l]);
          if (hist[m][l].size() > hd(m)) void'(hist[m][l].pop_back());
          if (cnt[m][l] < 15) cnt[m][l]++;
          else sat[m][l] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [7:0] lc;
    logic [1:0] ls;
    logic [5:0] tc, lw;
    logic       wd;
    for (int m = 0; m < 2; m++) begin
      lc = (m == 0) ? bus0.lane_count      : bus1.lane_count;
      ls = (m == 0) ? bus0.lane_sat        : bus1.lane_sat;
      tc = (m == 0) ? bus0.total_count     : bus1.total_count;
      lw = (m == 0) ? bus0.last_week_total : bus1.last_week_total;
      wd = (m == 0) ? bus0.week_done       : bus1.week_done;
      for (int l = 0; l < 2; l++) begin
        check($sformatf("d%0d_cnt%0d", m, l), 32'(lc[l*4 +: 4]), 32'(cnt[m][l]));
        check($sformatf("d%0d_sat%0d", m, l), 32'(ls[l]), 32'(sat[m][l]));
      end
      check($sformatf("d%0d_total", m), 32'(tc), 32'(sum_of(m)));
      check($sformatf("d%0d_lwt", m), 32'(lw), 32'(lwt[m]));
      check($sformatf("d%0d_wdone", m), 32'(wd), 32'(wd_e));
    end
  endtask

  task automatic drive(input logic [2:0] d, input logic [1:0] v, input logic [1:0] b,
                       input logic [23:0] p0, input logic [23:0] p1);
    day_d = d; valid_d = v; barrier_d = b; plate0_d = p0; plate1_d = p1;
    @(posedge clk);
    model_step();
    @(negedge clk);
    valid_d = 2'b00;
    compare_all();
  endtask

  // asserts reset mid-cycle, checks the cleared outputs, releases on negedge
  task automatic do_reset();
    valid_d = 2'b00;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // plate 0 is countable after reset
    drive(3'd1, 2'b01, 2'b00, 24'h000000, 24'h0);
    check("tp_plate0_cnt", 32'(bus0.lane_count[3:0]), 32'd1);
    check("tp_plate0_tot", 32'(bus0.total_count), 32'd1);

    // A,B,A,C: depth 4 suppresses the repeat, depth 1 does not
    do_reset();
    drive(3'd1, 2'b01, 2'b00, 24'hA, 24'h0);
    drive(3'd1, 2'b01, 2'b00, 24'hB, 24'h0);
    drive(3'd1, 2'b01, 2'b00, 24'hA, 24'h0);
    check("tp_aba_d1", 32'(bus1.lane_count[3:0]), 32'd3);
    drive(3'd1, 2'b01, 2'b00, 24'hC, 24'h0);
    check("tp_abac_d4", 32'(bus0.lane_count[3:0]), 32'd3);
    // same plate on consecutive cycles
    drive(3'd1, 2'b01, 2'b00, 24'hD, 24'h0);
    drive(3'd1, 2'b01, 2'b00, 24'hD, 24'h0);
    check("tp_consec_dup", 32'(bus1.lane_count[3:0]), 32'd5);

    // simultaneous lanes, then a blocked strobe
    do_reset();
    drive(3'd1, 2'b11, 2'b00, 24'h11, 24'h22);
    drive(3'd1, 2'b10, 2'b10, 24'h0, 24'h33);
    check("tp_two_lanes_c0", 32'(bus0.lane_count[3:0]), 32'd1);
    check("tp_two_lanes_c1", 32'(bus0.lane_count[7:4]), 32'd1);
    check("tp_two_lanes_tot", 32'(bus0.total_count), 32'd2);
    // same plate on both lanes in one cycle counts on each
    drive(3'd1, 2'b11, 2'b00, 24'h44, 24'h44);
    check("tp_same_plate_tot", 32'(bus0.total_count), 32'd4);

    // saturation with 16 distinct plates
    do_reset();
    for (int i = 0; i < 16; i++) drive(3'd1, 2'b01, 2'b00, 24'(32'h100 + i), 24'h0);
    check("tp_sat_cnt", 32'(bus0.lane_count[3:0]), 32'd15);
    check("tp_sat_flag", 32'(bus0.lane_sat[0]), 32'd1);
    check("tp_sat_tot", 32'(bus0.total_count), 32'd15);

    // week rollover with an event in the rollover cycle
    do_reset();
    for (int i = 0; i < 5; i++) drive(3'd7, 2'b01, 2'b00, 24'(32'h200 + i), 24'h0);
    drive(3'd1, 2'b10, 2'b00, 24'h0, 24'h300);
    check("tp_roll_wdone", 32'(bus0.week_done), 32'd1);
    check("tp_roll_lwt", 32'(bus0.last_week_total), 32'd5);
    check("tp_roll_tot", 32'(bus0.total_count), 32'd1);
    check("tp_roll_c1", 32'(bus0.lane_count[7:4]), 32'd1);
    drive(3'd1, 2'b00, 2'b00, 24'h0, 24'h0);
    check("tp_roll_pulse_end", 32'(bus0.week_done), 32'd0);
    // history survives rollover
    drive(3'd1, 2'b01, 2'b00, 24'h204, 24'h0);
    check("tp_hist_kept", 32'(bus0.lane_count[3:0]), 32'd0);

    // asynchronous reset mid-cycle, then a previously seen plate counts again
    do_reset();
    drive(3'd2, 2'b01, 2'b00, 24'h31, 24'h0);
    drive(3'd2, 2'b01, 2'b00, 24'h32, 24'h0);
    drive(3'd2, 2'b01, 2'b00, 24'h33, 24'h0);
    @(posedge clk);
    model_step();
    #2;
    do_reset();
    check("tp_async_tot", 32'(bus0.total_count), 32'd0);
    drive(3'd2, 2'b01, 2'b00, 24'h31, 24'h0);
    check("tp_async_recount", 32'(bus0.lane_count[3:0]), 32'd1);

    // randomized traffic with day changes and occasional resets
    for (int c = 0; c < 1500; c++) begin
      logic [2:0] d;
      d = day_d;
      if ($urandom_range(0, 11) == 0)
        d = ($urandom_range(0, 1) == 1) ? 3'd7 : 3'($urandom_range(1, 6));
      if ($urandom_range(0, 299) == 0) begin
        @(posedge clk);
        model_step();
        #2;
        do_reset();
      end
      drive(d, 2'($urandom), {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)},
            24'($urandom_range(0, 9)), 24'($urandom_range(0, 9)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vehicle_counter_multi.md
# vehicle_counter_multi

Clocked, parametrised vehicle counter for the car-park access system. It counts vehicles passing `N_LANES` barrier lanes and suppresses repeat reads of the same plate per lane using a per-lane history of recent plates. It keeps per-lane and total weekly counts with saturation, and on each week rollover it snapshots the finished week's total and clears the counters. It sits between the plate-reader front end and the occupancy/statistics display logic.

## Interface
- `N_LANES`, 2: number of barrier lanes (1..8).
- `PLATE_W`, 24: plate code width.
- `CNT_W`, 4: per-lane counter width.
- `HIST_DEPTH`, 4: recent-plate history entries per lane (1..16).
- `WEEK_END_DAY`, 3'd7: day code on which the week ends.
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `day` in 3: current day code, 1..7; quasi-static.
- `plate_valid` in N_LANES: per-lane one-cycle strobe; the plate is present this cycle.
- `plate` in N_LANES*PLATE_W: lane i occupies bits [i*PLATE_W +: PLATE_W].
- `barrier_n` in N_LANES: 0 means the lane barrier is open and passage is allowed.
- `lane_count` out N_LANES*CNT_W: per-lane count for the current week.
- `total_count` out CNT_W+$clog2(N_LANES)+1: sum of all lane counts for the current week.
- `lane_sat` out N_LANES: sticky flag; the lane counter has saturated this week.
- `week_done` out 1: one-cycle pulse on week rollover.
- `last_week_total` out same width as `total_count`: snapshot of `total_count` taken at rollover.

## Operation
- Lane i accepts an event in a cycle when `plate_valid[i]` is high, `barrier_n[i]` is 0, and `plate[i]` matches no valid entry in lane i's history.
- On an accepted event:
  - the plate is pushed into the history; the oldest entry is dropped when the history is full;
  - `lane_count[i]` increments.
- Rejected events change nothing, including the history.
- History entries carry valid bits. After reset no entry is valid, so plate 0 is countable.
- History is not cleared on week rollover: a duplicate read across midnight of the last day is still suppressed.
- Saturation: `lane_count` holds at 2^CNT_W−1. A further accepted event still updates the history and sets `lane_sat[i]`, but `total_count` does not increase.
- `total_count` is always exactly the sum of the `lane_count` outputs. When several lanes accept events in the same cycle, it increases by the number of lanes that actually incremented.
- Week state machine, two states:
  - IN_WEEK → LAST_DAY when `day == WEEK_END_DAY`.
  - LAST_DAY → IN_WEEK when `day != WEEK_END_DAY`. This is the rollover.
- On rollover:
  - `last_week_total` takes the current `total_count`;
  - all `lane_count` and `lane_sat` clear;
  - `week_done` pulses.
- An event accepted in the rollover cycle counts into the new week: the lane count becomes 1 and `total_count` becomes the number of lanes that accepted.
- Reset values: all counts, flags, `week_done`, `last_week_total` and history valid bits are 0; the state machine is in IN_WEEK. If `rst_n` is asserted mid-week, the current week's counts are lost.

## Timing
- Inputs are sampled on the rising edge of `clk`. Count and flag outputs reflect an event on the next cycle (latency 1).
- The history match is combinational against the registered history. Two reads of the same plate in consecutive cycles on one lane: the first counts, the second is rejected.
- `week_done` is high for exactly one cycle, the cycle after `day` leaves `WEEK_END_DAY`. `last_week_total` is valid from that same cycle and holds until the next rollover.
- The same plate arriving on different lanes in the same cycle counts once on each lane, because histories are per lane.

## Structure
- Shared package `vc_pkg` holds:
  - the day-code constants (`DAY_MON`=1 … `DAY_SUN`=7);
  - the week-state enum {IN_WEEK, LAST_DAY};
  - a width helper function for `total_count`.
- Sub-module `vc_lane`, instantiated `N_LANES` times, contains the history shift register with valid bits, the match logic, the saturating counter and the sat flag. It exports an `inc` strobe.
- The top level contains the popcount adder for `total_count`, the week state machine and the snapshot register.

## Test plan
- Reset, then lane 0 receives plate 0x000000 with barrier open → `lane_count[0]`=1, `total_count`=1.
- Lane 0 receives plates A, B, A, C, with HIST_DEPTH=4 → count 3. With HIST_DEPTH=1, the sequence A, B, A → count 3.
- Lanes 0 and 1 receive strobes in the same cycle with different plates; in another cycle lane 1 receives a strobe with `barrier_n`=1 → counts are 1/1, `total_count`=2; the blocked strobe has no effect.
- CNT_W=4, lane 0 fed 16 distinct plates → `lane_count[0]`=15, `lane_sat[0]`=1, `total_count`=15.
- Count 5 vehicles on day 7, then set `day`=1 in the same cycle as a new plate on lane 1:
  - `week_done` pulses once;
  - `last_week_total`=5;
  - `total_count`=1, and lane 1's count is 1.
- With counts at 3, assert `rst_n`=0 asynchronously mid-cycle → all outputs read 0 immediately; after release, a previously seen plate counts again.
